poly_wb_25: RTL and testbench
=============================

# poly_wb_25

Write-back buffer directly downstream of the 2×25-bit dual-modulus polynomial adder. It captures the adder's packed coefficient stream (one 50-bit word = two 25-bit residues per cycle) into a two-bank ping-pong coefficient store. Each completed polynomial becomes available to the next consumer (NTT or hash stage) through a registered random-access read port. The adder can fill one bank while the consumer reads the other.

## Interface
- WORDS, 256: packed words per polynomial (512 coefficients / 2)
- AW, 8: word address width, log2(WORDS)
- W, 50: packed word width ({coef_hi[24:0], coef_lo[24:0]})
- clk  in  1  rising-edge clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- in_flag  in  1  word valid; driven by the adder's out_flag
- din  in  W  packed coefficients; driven by the adder's dout
- in_last  in  1  end of burst; driven by the adder's out_rst; meaningful only with in_flag
- rd_en  in  1  read request for the current read bank
- rd_addr  in  AW  word address within the read bank
- rd_release  in  1  one-cycle pulse: consumer finished with the read bank
- err_clr  in  1  clears the sticky error flags
- rd_data  out  W  registered read data
- rd_valid  out  1  rd_data valid; one-cycle pulse
- poly_ready  out  1  read bank holds a complete polynomial
- wr_done  out  1  one-cycle pulse: a bank just completed
- wr_busy  out  1  a fill is in progress
- err_overflow  out  1  sticky: a word was dropped because no bank was free
- err_short  out  1  sticky: in_last arrived before WORDS words

## Operation
- State:
  - bank_full[1:0]
  - wr_bank and rd_bank, 1 bit each
  - wr_addr, AW bits
  - write FSM with states W_IDLE and W_FILL
- W_IDLE:
  - in_flag with bank_full[wr_bank]=0: write din at {wr_bank,0}, set wr_addr=1, go to W_FILL.
  - in_flag with bank_full[wr_bank]=1: drop the word, set err_overflow, stay in W_IDLE.
  - If WORDS=1 would apply, completion follows the W_FILL rules below. WORDS=1 is not supported.
- W_FILL:
  - in_flag: write din at {wr_bank,wr_addr}, then increment wr_addr.
  - Gaps with in_flag=0 are legal stalls. State and address hold.
  - Write at wr_addr=WORDS-1 (in_last optional) completes the bank:
    - bank_full[wr_bank]<=1, toggle wr_bank, wr_addr<=0, pulse wr_done, go to W_IDLE.
  - in_last with in_flag at wr_addr<WORDS-1:
    - The word is written, but the burst is discarded.
    - Set err_short, wr_addr<=0, go to W_IDLE. The bank is not marked full.
- Read:
  - rd_en with bank_full[rd_bank]=1: rd_data<=mem[{rd_bank,rd_addr}], rd_valid<=1.
  - Otherwise rd_valid<=0 and rd_data holds.
- Release:
  - rd_release with bank_full[rd_bank]=1: bank_full[rd_bank]<=0, toggle rd_bank.
  - rd_release with bank_full[rd_bank]=0 is ignored.
- Combinational outputs:
  - poly_ready = bank_full[rd_bank]
  - wr_busy = (state==W_FILL)
- Simultaneous completion (on wr_bank) and release (on rd_bank) act on different banks. Both take effect in the same cycle.
- err_clr clears both sticky errors. If an error event occurs in the same cycle, the set wins.
- Coefficients are stored verbatim; this block does no modular arithmetic. Both 25-bit fields are already reduced: the high field mod 33292289, the low field mod 16515073.

## Timing
- Reset values:
  - rd_data=0, rd_valid=0, wr_done=0, err_overflow=0, err_short=0
  - bank_full=0, wr_bank=0, rd_bank=0, wr_addr=0, FSM=W_IDLE
  - Memory contents are not reset.
- Reset mid-fill discards the partial burst.
- Write latency: the word is stored at the edge that samples in_flag.
- Completion edge E (the final word's edge):
  - poly_ready and wr_done are high in the cycle after E.
  - wr_done lasts exactly one cycle.
- Read latency: 1 cycle. rd_data and rd_valid appear after the edge that samples rd_en. Back-to-back reads give one word per cycle.
- rd_release at edge R: poly_ready reflects the other bank after R.
- A new burst may start in the cycle immediately after completion. There are no dead cycles.

## Structure
- Shared package/header raccoon_pkg:
  - Q_HI=33292289, Q_LO=16515073, COEF_W=25, POLY_N=512, WORDS, AW
  - FSM state encoding
- Sub-module poly_bank_ram:
  - Simple dual-port RAM of depth 2·WORDS, width W.
  - One synchronous write port and one registered read port.
  - No reset on the array; infers BRAM.
- The top level holds the FSM, pointers, flags and error logic.

## Test plan
- Full burst:
  - Stimulus: 256 consecutive words din={k,k+1000} for k=0..255, in_last on k=255.
  - Required: wr_done pulses once, poly_ready=1. Reading addr 37 returns {37,1037} one cycle later. err_*=0.
- Stalled burst:
  - Stimulus: 256 words with a 3-cycle in_flag gap after every 50th word.
  - Required: same contents as the full burst; wr_busy stays high through the gaps.
- Ping-pong:
  - Stimulus: two full bursts back to back, then a third word.
  - Required: bank_full=2'b11, the third word is dropped, err_overflow=1. rd_release moves poly_ready to bank 1 data.
- Short burst:
  - Stimulus: 10 words with in_last on word 9.
  - Required: err_short=1, poly_ready=0. A following full burst fills bank 0 and reads back correctly.
- Concurrency:
  - Stimulus: rd_release in the same cycle as bank 1 completes.
  - Required: bank 0 freed, bank 1 ready, poly_ready stays 1. rd_en with no bank ready gives rd_valid=0.
- Reset mid-fill:
  - Stimulus: assert rst after 100 words.
  - Required: all outputs 0 immediately (asynchronous reset). A subsequent full burst completes into bank 0.

Source files
------------

// File: rtl/raccoon_pkg.sv
// Shared constants for the raccoon polynomial pipeline: coefficient moduli,
// polynomial geometry and the write-back buffer FSM encoding.
package raccoon_pkg;

    localparam int Q_HI   = 33292289;
    localparam int Q_LO   = 16515073;
    localparam int COEF_W = 25;
    localparam int POLY_N = 512;
    localparam int WORDS  = POLY_N / 2;
    localparam int AW     = 8;
    localparam int W      = 2 * COEF_W;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_FILL = 1'b1;

endpackage

// File: rtl/poly_bank_ram.sv
// Simple dual-port coefficient store holding both ping-pong banks; the bank
// select is the address MSB. One synchronous write port, one registered read port.
module poly_bank_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // NOTE: the array is deliberately left out of reset so it maps onto block RAM;
    // only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Read data holds its last value when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/poly_wb_25.sv
// Write-back buffer after the 2x25-bit polynomial adder: fills one bank of a
// ping-pong coefficient store while the consumer reads the other.
module poly_wb_25
    import raccoon_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_flag,
    input  logic [W-1:0]  din,
    input  logic          in_last,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_release,
    input  logic          err_clr,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    output logic          poly_ready,
    output logic          wr_done,
    output logic          wr_busy,
    output logic          err_overflow,
    output logic          err_short
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    logic [0:0]    state;
    logic [1:0]    bank_full;
    logic [1:0]    bank_full_nxt;
    logic          wr_bank;
    logic          rd_bank;
    logic [AW-1:0] wr_addr;

    logic filling;
    logic accept;
    logic drop;
    logic at_last;
    logic complete;
    logic short_end;
    logic release_ok;
    logic rd_fire;

    assign filling    = (state == W_FILL);
    assign accept     = in_flag && (filling || !bank_full[wr_bank]);
    assign drop       = in_flag && !filling && bank_full[wr_bank];
    assign at_last    = (wr_addr == LAST_ADDR);
    assign complete   = accept && filling && at_last;
    assign short_end  = accept && filling && in_last && !at_last;
    assign release_ok = rd_release && bank_full[rd_bank];
    assign rd_fire    = rd_en && bank_full[rd_bank];

    assign poly_ready = bank_full[rd_bank];
    assign wr_busy    = filling;

    // Completion targets wr_bank (never full) and release targets rd_bank (always
    // full), so both updates can apply in the same cycle without conflict.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        bank_full_nxt = bank_full;
        if (complete)
            bank_full_nxt[wr_bank] = 1'b1;
        if (release_ok)
            bank_full_nxt[rd_bank] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= W_IDLE;
            bank_full    <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            wr_addr      <= '0;
            wr_done      <= 1'b0;
            rd_valid     <= 1'b0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;
            wr_done   <= complete;
            rd_valid  <= rd_fire;

            if (release_ok)
                rd_bank <= ~rd_bank;

            case (state)
                W_IDLE: begin
                    if (accept) begin
                        wr_addr <= AW'(1);
                        state   <= W_FILL;
                    end
                end
                W_FILL: begin
                    if (complete) begin
                        wr_bank <= ~wr_bank;
                        wr_addr <= '0;
                        state   <= W_IDLE;
                    end else if (short_end) begin
                        wr_addr <= '0;
                        state   <= W_IDLE;
                    end else if (accept) begin
                        wr_addr <= wr_addr + AW'(1);
                    end
                end
                default: state <= W_IDLE;
            endcase

            // Sticky errors: a new event in the clearing cycle wins.
            err_overflow <= drop      | (err_overflow & ~err_clr);
            err_short    <= short_end | (err_short    & ~err_clr);
        end
    end

    poly_bank_ram #(
        .ADDR_W (AW + 1),
        .DATA_W (W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .waddr ({wr_bank, wr_addr}),
        .wdata (din),
        .re    (rd_fire),
        .raddr ({rd_bank, rd_addr}),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_poly_wb_25.sv
// Self-checking bench for poly_wb_25: directed scenarios plus a randomized phase,
// all compared cycle by cycle against a queue-based bank model.
module tb_poly_wb_25;
    import raccoon_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_flag;
    logic [W-1:0]  din;
    logic          in_last;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_release;
    logic          err_clr;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          poly_ready;
    logic          wr_done;
    logic          wr_busy;
    logic          err_overflow;
    logic          err_short;

    int checks   = 0;
    int failures = 0;

    // Reference model: a burst is a queue of words, a bank is a copied snapshot.
    logic [W-1:0] m_bank [2][WORDS];
    logic [W-1:0] q [$];
    logic [1:0]   m_full;
    logic         m_wb, m_rb;
    logic [W-1:0] m_rd_data;
    logic         m_rd_valid, m_wr_done, m_ovf, m_short;

    poly_wb_25 dut (
        .clk          (clk),
        .rst          (rst),
        .in_flag      (in_flag),
        .din          (din),
        .in_last      (in_last),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_release   (rd_release),
        .err_clr      (err_clr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .poly_ready   (poly_ready),
        .wr_done      (wr_done),
        .wr_busy      (wr_busy),
        .err_overflow (err_overflow),
        .err_short    (err_short)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_full     = '0;
        m_wb       = 1'b0;
        m_rb       = 1'b0;
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_wr_done  = 1'b0;
        m_ovf      = 1'b0;
        m_short    = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] full0;
        logic       ovf_set, short_set;
        full0     = m_full;
        ovf_set   = 1'b0;
        short_set = 1'b0;
        m_wr_done = 1'b0;

        m_rd_valid = rd_en && full0[m_rb];
        if (m_rd_valid)
            m_rd_data = m_bank[m_rb][rd_addr];

        if (in_flag) begin
            if (q.size() == 0 && full0[m_wb]) begin
                ovf_set = 1'b1;
            end else begin
                q.push_back(din);
                if (q.size() == WORDS) begin
                    for (int i = 0; i < WORDS; i++)
                        m_bank[m_wb][i] = q[i];
                    m_full[m_wb] = 1'b1;
                    m_wb         = ~m_wb;
                    m_wr_done    = 1'b1;
                    q.delete();
                end else if (in_last) begin
                    short_set = 1'b1;
                    q.delete();
                end
            end
        end

        if (rd_release && full0[m_rb]) begin
            m_full[m_rb] = 1'b0;
            m_rb         = ~m_rb;
        end

        m_ovf   = ovf_set   | (m_ovf   & ~err_clr);
        m_short = short_set | (m_short & ~err_clr);
    endtask

    task automatic check_outputs();
        check("rd_valid",     64'(rd_valid),     64'(m_rd_valid));
        check("rd_data",      64'(rd_data),      64'(m_rd_data));
        check("poly_ready",   64'(poly_ready),   64'(m_full[m_rb]));
        check("wr_done",      64'(wr_done),      64'(m_wr_done));
        check("wr_busy",      64'(wr_busy),      64'(q.size() != 0));
        check("err_overflow", 64'(err_overflow), 64'(m_ovf));
        check("err_short",    64'(err_short),    64'(m_short));
    endtask

    task automatic idle_inputs();
        in_flag    = 1'b0;
        din        = '0;
        in_last    = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        rd_release = 1'b0;
        err_clr    = 1'b0;
    endtask

    // Inputs are set between edges; the model advances on the edge, outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        if (!rst)
            model_step();
        #1;
        check_outputs();
        idle_inputs();
    endtask

    task automatic send(input logic [W-1:0] d, input logic last);
        in_flag = 1'b1;
        din     = d;
        in_last = last;
        step();
    endtask

    function automatic logic [W-1:0] kword(input int k);
        return {25'(k), 25'(k + 1000)};
    endfunction

    task automatic full_burst();
        for (int k = 0; k < WORDS; k++)
            send(kword(k), k == WORDS - 1);
    endtask

    task automatic read_word(input int a);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        step();
    endtask

    task automatic release_bank();
        rd_release = 1'b1;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_rd_data",  64'(rd_data),  64'(0));
        check("rst_ready",    64'(poly_ready), 64'(0));
        check("rst_wr_done",  64'(wr_done),  64'(0));
        check("rst_busy",     64'(wr_busy),  64'(0));
        check("rst_ovf",      64'(err_overflow), 64'(0));
        check("rst_short",    64'(err_short), 64'(0));
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        do_reset();

        // Full burst into bank 0.
        full_burst();
        check("full_ready", 64'(poly_ready), 64'(1));
        check("full_done",  64'(wr_done),    64'(1));
        step();
        check("done_one_cycle", 64'(wr_done), 64'(0));
        read_word(37);
        check("full_addr37", 64'(rd_data), 64'({25'd37, 25'd1037}));
        check("full_valid",  64'(rd_valid), 64'(1));

        // Stalled burst into bank 1: 3-cycle gap after every 50th word.
        for (int k = 0; k < WORDS; k++) begin
            send(kword(k), k == WORDS - 1);
            if ((k + 1) % 50 == 0 && k != WORDS - 1) begin
                for (int g = 0; g < 3; g++) begin
                    step();
                    check("stall_busy", 64'(wr_busy), 64'(1));
                end
            end
        end

        // Both banks full: the next word is dropped.
        send(50'h123, 1'b0);
        check("pp_overflow", 64'(err_overflow), 64'(1));
        check("pp_busy",     64'(wr_busy),      64'(0));
        release_bank();
        check("pp_ready_b1", 64'(poly_ready), 64'(1));
        read_word(37);
        check("b1_addr37", 64'(rd_data), 64'({25'd37, 25'd1037}));
        read_word(255);
        check("b1_addr255", 64'(rd_data), 64'({25'd255, 25'd1255}));

        err_clr = 1'b1;
        step();
        check("clr_ovf", 64'(err_overflow), 64'(0));
        release_bank();

        // Short burst into bank 0.
        for (int k = 0; k < 10; k++)
            send(kword(k + 500), k == 9);
        check("short_err",   64'(err_short),  64'(1));
        check("short_ready", 64'(poly_ready), 64'(0));
        read_word(3);
        check("short_no_read", 64'(rd_valid), 64'(0));
        full_burst();
        read_word(200);
        check("after_short_200", 64'(rd_data), 64'({25'd200, 25'd1200}));

        // Bank 1 completes in the same cycle bank 0 is released.
        for (int k = 0; k < WORDS; k++) begin
            rd_release = (k == WORDS - 1);
            send(kword(k + 3000), k == WORDS - 1);
        end
        check("conc_ready", 64'(poly_ready), 64'(1));
        read_word(5);
        check("conc_b1_5", 64'(rd_data), 64'({25'd3005, 25'd4005}));
        release_bank();
        check("conc_empty", 64'(poly_ready), 64'(0));
        read_word(5);
        check("conc_no_read", 64'(rd_valid), 64'(0));

        // Randomized phase with reduced coefficients.
        for (int c = 0; c < 4000; c++) begin
            in_flag = ($urandom_range(3) != 0);
            din     = {25'($urandom % Q_HI), 25'($urandom % Q_LO)};
            if (q.size() == WORDS - 1)
                in_last = ($urandom_range(3) != 0);
            else
                in_last = (q.size() > 0) && ($urandom_range(799) == 0);
            rd_en      = $urandom_range(1) == 1;
            rd_addr    = AW'($urandom);
            rd_release = ($urandom_range(199) == 0);
            err_clr    = ($urandom_range(99) == 0);
            step();
        end

        // Reset mid-fill discards the partial burst.
        do_reset();
        for (int k = 0; k < 100; k++)
            send(kword(k + 7000), 1'b0);
        @(negedge clk);
        do_reset();
        full_burst();
        check("rst_refill_ready", 64'(poly_ready), 64'(1));
        read_word(99);
        check("rst_refill_99", 64'(rd_data), 64'({25'd99, 25'd1099}));
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
